// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file readout engine: FSM state
// encoding, default widths and the wrap-around beat-count helper.
package regfile_dump_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        SUM  = 2'd3
    } state_t;

    // Number of register beats for a first..last walk that wraps modulo 2^addr_w.
    function automatic int unsigned beat_count(
        input int unsigned first_idx,
        input int unsigned last_idx,
        input int unsigned addr_w
    );
        int unsigned mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return ((last_idx - first_idx) & mask) + 32'd1;
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// Register-file readout engine for the CPU debug path.
// Walks a wrap-around register range through a spare asynchronous read
// port and streams each value out over valid/ready, tagged with its index.
// Optional trailing checksum beat: define REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              out_sum,
    output logic              done
);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_end;
    logic [DATA_W-1:0]   r_outData;
    logic [ADDR_W-1:0]   r_outIdx;
    logic                r_outValid;
    logic                r_outLast;
    logic                r_done;
    logic                w_handshake;
    logic                w_atEnd;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   r_acc;
    logic                r_outSum;
`endif

    assign w_handshake = r_outValid & out_ready;
    assign w_atEnd     = (r_idx == r_end);

    assign busy      = (r_state != IDLE);
    assign rf_addr   = r_idx;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_idx   = r_outIdx;
    assign out_last  = r_outLast;
    assign done      = r_done;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    assign out_sum   = r_outSum;
`else
    assign out_sum   = 1'b0;
`endif

    // State register; reset abandons any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one READ/SEND pair per register, optional SUM beat at the end.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                w_nextState = SEND;
            end
            SEND: begin
                if (w_handshake) begin
                    if (!w_atEnd) begin
                        w_nextState = READ;
                    end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        w_nextState = SUM;
`else
                        w_nextState = IDLE;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            SUM: begin
                if (w_handshake) begin
                    w_nextState = IDLE;
                end
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Walk pointer, output beat register, checksum and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_end      <= '0;
            r_outData  <= '0;
            r_outIdx   <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_done     <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_acc      <= '0;
            r_outSum   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx <= first;
                        r_end <= last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        r_acc <= '0;
`endif
                    end
                end
                READ: begin
                    r_outData  <= rf_rdata;
                    r_outIdx   <= r_idx;
                    r_outValid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    r_outLast  <= 1'b0;
                    r_outSum   <= 1'b0;
                    r_acc      <= r_acc + rf_rdata;
`else
                    r_outLast  <= w_atEnd;
`endif
                end
                SEND: begin
                    if (w_handshake) begin
                        if (!w_atEnd) begin
                            r_idx      <= r_idx + ADDR_W'(1);
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                        end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            r_outData  <= r_acc;
                            r_outIdx   <= r_end;
                            r_outSum   <= 1'b1;
                            r_outLast  <= 1'b1;
`else
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                SUM: begin
                    if (w_handshake) begin
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        r_outSum   <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a reference model expands each dump
// request into its expected beats (scoreboard queue); an independent monitor
// pops and compares on every handshake and checks stall stability.
// Honours REGFILE_DUMP_CHECKSUM_EN the same way as the design.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
        logic          sum;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] firstIdx = '0;
    logic [AW-1:0] lastIdx = '0;
    logic          busy;
    logic [AW-1:0] rfAddr;
    logic [DW-1:0] rfRdata;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [DW-1:0] outData;
    logic [AW-1:0] outIdx;
    logic          outLast;
    logic          outSum;
    logic          done;

    logic          wrEn = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] wrData = '0;
    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] refRf [NREG];

    beat_t         sbQ [$];
    int            cmpCount = 0;
    int            errCount = 0;
    int            readyMode = 0;
    int            beatsThisDump = 0;
    int            stallCnt = 0;

    regfile_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .first    (firstIdx),
        .last     (lastIdx),
        .busy     (busy),
        .rf_addr  (rfAddr),
        .rf_rdata (rfRdata),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData),
        .out_idx  (outIdx),
        .out_last (outLast),
        .out_sum  (outSum),
        .done     (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Register file write port; a write lands after the edge, so a same-edge read sees the old value
    always @(posedge clk) begin
        if (wrEn) rf[wrAddr] <= wrData;
    end

    assign rfRdata = rf[rfAddr];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        cmpCount++;
        errCount++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Sink behaviour: 0 always ready, 1 random, 2 stall second beat 5 cycles, 3 never ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: outReady = 1'b1;
                1: outReady = ($urandom_range(0, 3) != 0);
                2: begin
                    if (beatsThisDump == 1 && outValid && stallCnt < 5) begin
                        outReady = 1'b0;
                        stallCnt++;
                    end else begin
                        outReady = 1'b1;
                    end
                end
                default: outReady = 1'b0;
            endcase
        end
    end

    // Monitor: stall stability and scoreboard compare on each handshake
    initial begin
        bit            stallPending;
        logic [DW-1:0] heldData;
        logic [AW-1:0] heldIdx;
        logic          heldLast;
        beat_t         exp;
        stallPending = 1'b0;
        heldData = '0;
        heldIdx = '0;
        heldLast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stallPending = 1'b0;
            end else begin
                if (stallPending) begin
                    checkOutput("stallValid", outValid, 1);
                    checkOutput("stallData", outData, heldData);
                    checkOutput("stallIdx", outIdx, heldIdx);
                    checkOutput("stallLast", outLast, heldLast);
                end
                if (outValid && !outReady) begin
                    stallPending = 1'b1;
                    heldData = outData;
                    heldIdx = outIdx;
                    heldLast = outLast;
                end else begin
                    stallPending = 1'b0;
                end
                if (outValid && outReady) begin
                    beatsThisDump++;
                    if (sbQ.size() == 0) begin
                        reportFail("unexpectedBeat");
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("beatData", outData, exp.data);
                        checkOutput("beatIdx", outIdx, exp.idx);
                        checkOutput("beatLast", outLast, exp.last);
                        checkOutput("beatSum", outSum, exp.sum);
                    end
                end
            end
        end
    end

    // Reference model: expand a dump request into its expected beat sequence
    task automatic pushExpected(input int f, input int l, output int nBeats);
        int            n;
        logic [DW-1:0] acc;
        beat_t         b;
        n = int'(beat_count(f, l, AW));
        acc = '0;
        for (int k = 0; k < n; k++) begin
            int r;
            r = (f + k) % NREG;
            b.data = refRf[r];
            b.idx = AW'(r);
            b.sum = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (k == n - 1);
`endif
            acc = acc + refRf[r];
            sbQ.push_back(b);
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        b.data = acc;
        b.idx = AW'(l);
        b.last = 1'b1;
        b.sum = 1'b1;
        sbQ.push_back(b);
        nBeats = n + 1;
`else
        nBeats = n;
`endif
    endtask

    // Fill the register file (pattern i*0x11 or random); called at posedge+1
    task automatic loadRf(input bit randomData);
        for (int i = 0; i < NREG; i++) begin
            wrEn = 1'b1;
            wrAddr = AW'(i);
            wrData = randomData ? $urandom : DW'(i * 32'h11);
            refRf[i] = wrData;
            @(posedge clk);
            #1;
        end
        wrEn = 1'b0;
    endtask

    // Issue one dump and wait for done; optionally poke an ignored start or a same-edge write
    task automatic applyStimulus(input int f, input int l, input bit injectStart, input bit writeAtRead);
        int  nBeats;
        int  cycles;
        bit  gotDone;
        pushExpected(f, l, nBeats);
        beatsThisDump = 0;
        stallCnt = 0;
        firstIdx = AW'(f);
        lastIdx = AW'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyAfterStart", busy, 1);
        if (writeAtRead) begin
            wrEn = 1'b1;
            wrAddr = AW'(f);
            wrData = 32'hDEADBEEF;
            refRf[f] = 32'hDEADBEEF;
        end
        cycles = 0;
        gotDone = 1'b0;
        while (!gotDone && cycles < 3000) begin
            @(posedge clk);
            cycles++;
            #1;
            wrEn = 1'b0;
            if (injectStart && cycles == 10) begin
                start = 1'b1;
                firstIdx = AW'(5);
                lastIdx = AW'(5);
            end else begin
                start = 1'b0;
            end
            if (done) gotDone = 1'b1;
        end
        if (!gotDone) begin
            reportFail("doneTimeout");
        end else begin
            checkOutput("busyAtDone", busy, 0);
            if (readyMode == 0) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                checkOutput("dumpCycles", cycles, 2 * (nBeats - 1) + 1);
`else
                checkOutput("dumpCycles", cycles, 2 * nBeats);
`endif
            end
            @(posedge clk);
            #1;
            checkOutput("donePulseWidth", done, 0);
        end
        checkOutput("beatCount", beatsThisDump, nBeats);
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        sbQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_valid"}, outValid, 0);
        checkOutput({tag, "_data"}, outData, 0);
        checkOutput({tag, "_idx"}, outIdx, 0);
        checkOutput({tag, "_rfAddr"}, rfAddr, 0);
        checkOutput({tag, "_last"}, outLast, 0);
        checkOutput({tag, "_sum"}, outSum, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // Main test sequence
    initial begin
        int waitCycles;
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] full dump 0..31, sink always ready");
        loadRf(1'b0);
        readyMode = 0;
        applyStimulus(0, 31, 1'b0, 1'b0);

        $display("[TB] wrap-around dump 30..1");
        applyStimulus(30, 1, 1'b0, 1'b0);

        $display("[TB] backpressure on second beat");
        readyMode = 2;
        applyStimulus(10, 14, 1'b0, 1'b0);
        checkOutput("stallCycles", stallCnt, 5);

        $display("[TB] start while busy is ignored");
        readyMode = 1;
        applyStimulus(0, 31, 1'b1, 1'b0);

        $display("[TB] same-edge write at READ dumps old value");
        readyMode = 0;
        applyStimulus(3, 3, 1'b0, 1'b1);
        applyStimulus(3, 3, 1'b0, 1'b0);

        $display("[TB] reset during SEND");
        readyMode = 3;
        firstIdx = AW'(0);
        lastIdx = AW'(31);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitCycles = 0;
        while (!outValid && waitCycles < 10) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        checkOutput("midSendValid", outValid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        sbQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        readyMode = 0;
        applyStimulus(7, 7, 1'b0, 1'b0);

        $display("[TB] randomized dumps");
        for (int t = 0; t < 6; t++) begin
            loadRf(1'b1);
            readyMode = int'($urandom_range(0, 1));
            applyStimulus(int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
